// File: rtl/eth_tx_arb.sv
// Frame-atomic 2:1 round-robin arbiter merging two eth_encap streams onto the MAC TX stream.
// Define ETH_TX_ARB_STATS_EN to add per-port frame counters and an errored-frame counter.
module eth_tx_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  eth_clk,
  input  logic                  sys_rst156,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_tkeep,
  input  logic                  s0_tlast,
  input  logic                  s0_tuser,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_tkeep,
  input  logic                  s1_tlast,
  input  logic                  s1_tuser,
  output logic                  eth_tx_tvalid,
  input  logic                  eth_tx_tready,
  output logic [DATA_WIDTH-1:0] eth_tx_tdata,
  output logic [KEEP_WIDTH-1:0] eth_tx_tkeep,
  output logic                  eth_tx_tlast,
  output logic                  eth_tx_tuser
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [31:0]           stat_frames0,
  output logic [31:0]           stat_frames1,
  output logic [31:0]           stat_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  last_grant_r;
  logic                  last_grant_nxt_s;
  logic                  out_ready_s;
  logic                  beat_acc_s;
  logic [DATA_WIDTH-1:0] mux_tdata_s;
  logic [KEEP_WIDTH-1:0] mux_tkeep_s;
  logic                  mux_tlast_s;
  logic                  mux_tuser_s;

  // The output slice can take a beat when empty or draining this cycle.
  assign out_ready_s = !eth_tx_tvalid || eth_tx_tready;
  assign beat_acc_s  = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);

  // Next-state, grant release and per-port ready generation.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    s0_tready        = 1'b0;
    s1_tready        = 1'b0;
    case (state_r)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_nxt_s = last_grant_r ? GRANT0 : GRANT1;
        end else if (s0_tvalid) begin
          state_nxt_s = GRANT0;
        end else if (s1_tvalid) begin
          state_nxt_s = GRANT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT0: begin
        s0_tready = out_ready_s;
        if (s0_tvalid && out_ready_s && s0_tlast) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = 1'b0;
        end else begin
          state_nxt_s = GRANT0;
        end
      end
      GRANT1: begin
        s1_tready = out_ready_s;
        if (s1_tvalid && out_ready_s && s1_tlast) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = 1'b1;
        end else begin
          state_nxt_s = GRANT1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Source mux for the beat being loaded into the output slice.
  always_comb begin
    mux_tdata_s = s0_tdata;
    mux_tkeep_s = s0_tkeep;
    mux_tlast_s = s0_tlast;
    mux_tuser_s = s0_tuser;
    if (state_r == GRANT1) begin
      mux_tdata_s = s1_tdata;
      mux_tkeep_s = s1_tkeep;
      mux_tlast_s = s1_tlast;
      mux_tuser_s = s1_tuser;
    end else begin
      mux_tdata_s = s0_tdata;
      mux_tkeep_s = s0_tkeep;
      mux_tlast_s = s0_tlast;
      mux_tuser_s = s0_tuser;
    end
  end

  // Arbitration state register; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge eth_clk) begin
    if (sys_rst156) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Registered output slice: load on accept, clear valid once the MAC drains it.
  always_ff @(posedge eth_clk) begin
    if (sys_rst156) begin
      eth_tx_tvalid <= 1'b0;
      eth_tx_tdata  <= '0;
      eth_tx_tkeep  <= '0;
      eth_tx_tlast  <= 1'b0;
      eth_tx_tuser  <= 1'b0;
    end else if (beat_acc_s) begin
      eth_tx_tvalid <= 1'b1;
      eth_tx_tdata  <= mux_tdata_s;
      eth_tx_tkeep  <= mux_tkeep_s;
      eth_tx_tlast  <= mux_tlast_s;
      eth_tx_tuser  <= mux_tuser_s;
    end else if (eth_tx_tready) begin
      eth_tx_tvalid <= 1'b0;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] frames0_r;
  logic [31:0] frames1_r;
  logic [31:0] err_r;

  assign stat_frames0 = frames0_r;
  assign stat_frames1 = frames1_r;
  assign stat_err     = err_r;

  // Frame and errored-frame counters, wrapping naturally at 32 bits.
  always_ff @(posedge eth_clk) begin
    if (sys_rst156) begin
      frames0_r <= 32'd0;
      frames1_r <= 32'd0;
      err_r     <= 32'd0;
    end else begin
      if (s0_tvalid && s0_tready && s0_tlast) begin
        frames0_r <= frames0_r + 32'd1;
      end
      if (s1_tvalid && s1_tready && s1_tlast) begin
        frames1_r <= frames1_r + 32'd1;
      end
      if (beat_acc_s && mux_tlast_s && mux_tuser_s) begin
        err_r <= err_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: queue-driven AXI-Stream sources and an output capture queue.
// Define ETH_TX_ARB_STATS_EN to also exercise the statistics counters.
module tb_eth_tx_arb;

  logic        eth_clk = 1'b0;
  logic        sys_rst156 = 1'b1;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tready, s1_tready;
  logic [63:0] s0_tdata = 64'd0, s1_tdata = 64'd0;
  logic [7:0]  s0_tkeep = 8'd0, s1_tkeep = 8'd0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic        s0_tuser = 1'b0, s1_tuser = 1'b0;
  logic        eth_tx_tvalid;
  logic        eth_tx_tready = 1'b1;
  logic [63:0] eth_tx_tdata;
  logic [7:0]  eth_tx_tkeep;
  logic        eth_tx_tlast;
  logic        eth_tx_tuser;
`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] stat_frames0, stat_frames1, stat_err;
`endif

  always #5 eth_clk = ~eth_clk;

  eth_tx_arb dut (
    .eth_clk       (eth_clk),
    .sys_rst156    (sys_rst156),
    .s0_tvalid     (s0_tvalid),
    .s0_tready     (s0_tready),
    .s0_tdata      (s0_tdata),
    .s0_tkeep      (s0_tkeep),
    .s0_tlast      (s0_tlast),
    .s0_tuser      (s0_tuser),
    .s1_tvalid     (s1_tvalid),
    .s1_tready     (s1_tready),
    .s1_tdata      (s1_tdata),
    .s1_tkeep      (s1_tkeep),
    .s1_tlast      (s1_tlast),
    .s1_tuser      (s1_tuser),
    .eth_tx_tvalid (eth_tx_tvalid),
    .eth_tx_tready (eth_tx_tready),
    .eth_tx_tdata  (eth_tx_tdata),
    .eth_tx_tkeep  (eth_tx_tkeep),
    .eth_tx_tlast  (eth_tx_tlast),
`ifdef ETH_TX_ARB_STATS_EN
    .stat_frames0  (stat_frames0),
    .stat_frames1  (stat_frames1),
    .stat_err      (stat_err),
`endif
    .eth_tx_tuser  (eth_tx_tuser)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [31:0] c;
  } cap_t;

  beat_t       q0[$];
  beat_t       q1[$];
  cap_t        cap[$];
  logic [31:0] cyc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        acc0 = 1'b0, acc1 = 1'b0, oacc = 1'b0, s1_seen = 1'b0;
  beat_t       obeat;
  logic [31:0] ocyc = 32'd0;

  always @(posedge eth_clk) cyc <= cyc + 32'd1;

  // Handshakes are judged mid-cycle, where inputs and ready are stable up to the next edge.
  always @(negedge eth_clk) begin
    acc0  = !sys_rst156 && s0_tvalid && s0_tready;
    acc1  = !sys_rst156 && s1_tvalid && s1_tready;
    oacc  = !sys_rst156 && eth_tx_tvalid && eth_tx_tready;
    obeat = {eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser};
    ocyc  = cyc;
    if (s1_tready === 1'b1) s1_seen = 1'b1;
  end

  // Sources present their queue heads; the capture queue records beats the MAC took.
  always @(posedge eth_clk) begin
    #2;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (oacc) cap.push_back({obeat, ocyc});
    s0_tvalid = (q0.size() > 0);
    if (q0.size() > 0) {s0_tdata, s0_tkeep, s0_tlast, s0_tuser} = q0[0];
    else {s0_tdata, s0_tkeep, s0_tlast, s0_tuser} = '0;
    s1_tvalid = (q1.size() > 0);
    if (q1.size() > 0) {s1_tdata, s1_tkeep, s1_tlast, s1_tuser} = q1[0];
    else {s1_tdata, s1_tkeep, s1_tlast, s1_tuser} = '0;
  end

  task automatic tick();
    @(posedge eth_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst156 = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) tick();
    sys_rst156 = 1'b0;
    tick();
    cap.delete();
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 300 && cap.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    sys_rst156 = 1'b1;
    repeat (3) tick();
    sys_rst156 = 1'b0;
    tick();
    n_vec++; if (eth_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", eth_tx_tvalid); end
    n_vec++; if (eth_tx_tdata !== 64'd0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", eth_tx_tdata); end
    n_vec++; if (eth_tx_tkeep !== 8'd0) begin n_err++; $display("FAIL reset_tkeep: got %h want 0", eth_tx_tkeep); end
    n_vec++; if (eth_tx_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", eth_tx_tlast); end
    n_vec++; if (eth_tx_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser: got %b want 0", eth_tx_tuser); end
    n_vec++; if (s0_tready !== 1'b0) begin n_err++; $display("FAIL reset_s0_tready: got %b want 0", s0_tready); end
    n_vec++; if (s1_tready !== 1'b0) begin n_err++; $display("FAIL reset_s1_tready: got %b want 0", s1_tready); end
  endtask

  task automatic test_single_frame();
    logic [63:0] exp_d [3] = '{64'h11, 64'h22, 64'h33};
    logic [7:0]  exp_k [3] = '{8'hFF, 8'hFF, 8'h0F};
    logic [31:0] t0;
    eth_tx_tready = 1'b1;
    s1_seen = 1'b0;
    cap.delete();
    q0.push_back({64'h11, 8'hFF, 1'b0, 1'b0});
    q0.push_back({64'h22, 8'hFF, 1'b0, 1'b0});
    q0.push_back({64'h33, 8'h0F, 1'b1, 1'b0});
    t0 = cyc;
    wait_cap(3);
    n_vec++; if (cap.size() !== 3) begin n_err++; $display("FAIL single_count: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (cap[i].b.d !== exp_d[i]) begin n_err++; $display("FAIL single_data[%0d]: got %h want %h", i, cap[i].b.d, exp_d[i]); end
      n_vec++; if (cap[i].b.k !== exp_k[i]) begin n_err++; $display("FAIL single_keep[%0d]: got %h want %h", i, cap[i].b.k, exp_k[i]); end
      n_vec++; if (cap[i].b.l !== (i == 2)) begin n_err++; $display("FAIL single_last[%0d]: got %b want %b", i, cap[i].b.l, (i == 2)); end
      n_vec++; if (cap[i].c !== t0 + 32'd2 + 32'(i)) begin n_err++; $display("FAIL single_cycle[%0d]: got %0d want %0d", i, cap[i].c, t0 + 32'd2 + 32'(i)); end
    end
    n_vec++; if (s1_seen !== 1'b0) begin n_err++; $display("FAIL single_s1_tready: got %b want 0", s1_seen); end
  endtask

  task automatic test_tie();
    logic [63:0] exp_d [4] = '{64'hA001, 64'hA002, 64'hB001, 64'hB002};
    apply_reset();
    q0.push_back({64'hA001, 8'hFF, 1'b0, 1'b0});
    q0.push_back({64'hA002, 8'hFF, 1'b1, 1'b0});
    q1.push_back({64'hB001, 8'hFF, 1'b0, 1'b0});
    q1.push_back({64'hB002, 8'hFF, 1'b1, 1'b0});
    wait_cap(4);
    n_vec++; if (cap.size() !== 4) begin n_err++; $display("FAIL tie_count: got %0d want 4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (cap[i].b.d !== exp_d[i]) begin n_err++; $display("FAIL tie_data[%0d]: got %h want %h", i, cap[i].b.d, exp_d[i]); end
      n_vec++; if (cap[i].b.l !== (i % 2 == 1)) begin n_err++; $display("FAIL tie_last[%0d]: got %b want %b", i, cap[i].b.l, (i % 2 == 1)); end
    end
    n_vec++; if (cap[2].c - cap[1].c !== 32'd2) begin n_err++; $display("FAIL tie_bubble: got gap %0d want 2", cap[2].c - cap[1].c); end
  endtask

  task automatic test_round_robin();
    logic [63:0] d;
    cap.delete();
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 2; b++) begin
        q0.push_back({{40'd0, 8'hE0, 8'd0, 8'(f), 8'(b)}, 8'hFF, (b == 1), 1'b0});
        q1.push_back({{40'd0, 8'hE0, 8'd1, 8'(f), 8'(b)}, 8'hFF, (b == 1), 1'b0});
      end
    end
    wait_cap(16);
    n_vec++; if (cap.size() !== 16) begin n_err++; $display("FAIL rr_count: got %0d want 16", cap.size()); end
    for (int i = 0; i < 16; i++) begin
      d = {40'd0, 8'hE0, 8'((i / 2) % 2), 8'(i / 4), 8'(i % 2)};
      n_vec++; if (cap[i].b.d !== d) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, cap[i].b.d, d); end
      n_vec++; if (cap[i].b.l !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_last[%0d]: got %b want %b", i, cap[i].b.l, (i % 2 == 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    eth_tx_tready = 1'b1;
    cap.delete();
    for (int i = 1; i <= 6; i++) q0.push_back({64'hC0 + 64'(i), (i == 6) ? 8'h03 : 8'hFF, (i == 6), (i == 6)});
    for (int i = 0; i < 100 && cap.size() < 2; i++) tick();
    eth_tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (eth_tx_tdata !== 64'hC4) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, eth_tx_tdata, 64'hC4); end
      n_vec++; if (eth_tx_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, eth_tx_tvalid); end
      n_vec++; if (s0_tready !== 1'b0) begin n_err++; $display("FAIL bp_s0_tready[%0d]: got %b want 0", i, s0_tready); end
    end
    eth_tx_tready = 1'b1;
    wait_cap(6);
    tick();
    n_vec++; if (cap.size() !== 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", cap.size()); end
    for (int i = 0; i < 6; i++) begin
      d = 64'hC1 + 64'(i);
      n_vec++; if (cap[i].b.d !== d) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, cap[i].b.d, d); end
      n_vec++; if (cap[i].b.u !== (i == 5)) begin n_err++; $display("FAIL bp_user[%0d]: got %b want %b", i, cap[i].b.u, (i == 5)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    eth_tx_tready = 1'b1;
    cap.delete();
    for (int i = 1; i <= 4; i++) q1.push_back({64'hD0 + 64'(i), 8'hFF, (i == 4), 1'b0});
    for (int i = 0; i < 100; i++) begin
      @(posedge eth_clk);
      #3;
      if (q1.size() == 3) break;
    end
    n_vec++; if (q1.size() !== 3) begin n_err++; $display("FAIL rstmid_reach_beat2: got %0d left want 3", q1.size()); end
    sys_rst156 = 1'b1;
    q1.delete();
    tick();
    sys_rst156 = 1'b0;
    n_vec++; if (eth_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid: got %b want 0", eth_tx_tvalid); end
    n_vec++; if (eth_tx_tdata !== 64'd0) begin n_err++; $display("FAIL rstmid_tdata: got %h want 0", eth_tx_tdata); end
    n_vec++; if (eth_tx_tkeep !== 8'd0) begin n_err++; $display("FAIL rstmid_tkeep: got %h want 0", eth_tx_tkeep); end
    n_vec++; if (eth_tx_tlast !== 1'b0) begin n_err++; $display("FAIL rstmid_tlast: got %b want 0", eth_tx_tlast); end
    n_vec++; if (s0_tready !== 1'b0) begin n_err++; $display("FAIL rstmid_s0_tready: got %b want 0", s0_tready); end
    n_vec++; if (s1_tready !== 1'b0) begin n_err++; $display("FAIL rstmid_s1_tready: got %b want 0", s1_tready); end
    cap.delete();
    q0.push_back({64'hF0, 8'hFF, 1'b1, 1'b0});
    q1.push_back({64'hF1, 8'hFF, 1'b1, 1'b0});
    wait_cap(2);
    n_vec++; if (cap[0].b.d !== 64'hF0) begin n_err++; $display("FAIL rstmid_first_grant: got %h want %h", cap[0].b.d, 64'hF0); end
    n_vec++; if (cap[1].b.d !== 64'hF1) begin n_err++; $display("FAIL rstmid_second_grant: got %h want %h", cap[1].b.d, 64'hF1); end
  endtask

`ifdef ETH_TX_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    force dut.frames0_r = 32'hFFFFFFFF;
    tick();
    release dut.frames0_r;
    q0.push_back({64'h51, 8'hFF, 1'b0, 1'b0});
    q0.push_back({64'h52, 8'hFF, 1'b1, 1'b1});
    wait_cap(2);
    tick();
    n_vec++; if (stat_frames0 !== 32'd0) begin n_err++; $display("FAIL stats_frames0_wrap: got %h want 0", stat_frames0); end
    n_vec++; if (stat_err !== 32'd1) begin n_err++; $display("FAIL stats_err: got %h want 1", stat_err); end
    n_vec++; if (stat_frames1 !== 32'd0) begin n_err++; $display("FAIL stats_frames1: got %h want 0", stat_frames1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid_frame();
`ifdef ETH_TX_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
